// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one memory read at a time and
// buffers the returned instruction with its PC for decode.
module ifu_fetch #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_jmp_en,
  input  logic [DATA_WIDTH-1:0] i_jmp_pc,
  output logic                  o_ifu_ram_req,
  output logic [DATA_WIDTH-1:0] o_ifu_ram_addr,
  input  logic                  i_ram_ready,
  input  logic                  i_ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_ram_inst,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [DATA_WIDTH-1:0] o_ifu_pc,
  output logic [DATA_WIDTH-1:0] o_ifu_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_drop;
  logic [DATA_WIDTH-1:0] r_ifu_pc;
  logic [DATA_WIDTH-1:0] r_ifu_inst;
  logic [DATA_WIDTH-1:0] w_jmp_tgt;
  logic [DATA_WIDTH-1:0] w_fetch_next;

  assign w_jmp_tgt    = {i_jmp_pc[DATA_WIDTH-1:2], 2'b00};
  assign w_fetch_next = r_fetch_pc + {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  // Request is gated by reset so nothing is presented to memory while held in reset.
  assign o_ifu_ram_req  = (r_state == S_REQ) && i_sys_rst_n;
  assign o_ifu_ram_addr = r_pc;
  assign o_sys_valid    = (r_state == S_HOLD) && !i_jmp_en;
  assign o_ifu_pc       = r_ifu_pc;
  assign o_ifu_inst     = r_ifu_inst;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_ifu_pc   <= {DATA_WIDTH{1'b0}};
      r_ifu_inst <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_ram_ready) begin
            r_fetch_pc <= r_pc;
            r_state    <= S_WAIT;
            if (i_jmp_en) begin
              r_drop <= 1'b1;
              r_pc   <= w_jmp_tgt;
            end
          end else if (i_jmp_en) begin
            r_pc <= w_jmp_tgt;
          end
        end
        S_WAIT: begin
          // A jump landing in the same cycle as the response squashes it too.
          if (i_ram_rsp_valid) begin
            if (r_drop || i_jmp_en) begin
              r_drop <= 1'b0;
              if (i_jmp_en) begin
                r_pc <= w_jmp_tgt;
              end
            end else begin
              r_ifu_inst <= i_ram_inst;
              r_ifu_pc   <= r_fetch_pc;
              r_pc       <= w_fetch_next;
            end
            r_state <= (r_drop || i_jmp_en) ? S_REQ : S_HOLD;
          end else if (i_jmp_en) begin
            r_drop <= 1'b1;
            r_pc   <= w_jmp_tgt;
          end
        end
        S_HOLD: begin
          if (i_jmp_en) begin
            r_pc    <= w_jmp_tgt;
            r_state <= S_REQ;
          end else if (i_sys_ready) begin
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed table-driven bench for ifu_fetch: one record per clock cycle,
// plus hand sequences for reset-in-flight and decode back-pressure.
module tb_ifu_fetch;

  typedef struct {
    logic        jmp;
    logic [31:0] jpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] inst;
    logic        srdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic        ram_ready;
  logic        rsp_valid;
  logic [31:0] ram_inst;
  logic        sys_valid;
  logic        sys_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  ifu_fetch dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_jmp_en        (jmp_en),
    .i_jmp_pc        (jmp_pc),
    .o_ifu_ram_req   (ram_req),
    .o_ifu_ram_addr  (ram_addr),
    .i_ram_ready     (ram_ready),
    .i_ram_rsp_valid (rsp_valid),
    .i_ram_inst      (ram_inst),
    .o_sys_valid     (sys_valid),
    .i_sys_ready     (sys_ready),
    .o_ifu_pc        (ifu_pc),
    .o_ifu_inst      (ifu_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic jmp, logic [31:0] jpc, logic rdy, logic rsp,
                              logic [31:0] inst, logic srdy, logic e_req,
                              logic [31:0] e_addr, logic e_val, logic [31:0] e_pc,
                              logic [31:0] e_inst);
    vec_t v;
    v.jmp = jmp; v.jpc = jpc; v.rdy = rdy; v.rsp = rsp; v.inst = inst; v.srdy = srdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic compare(string name, logic e_req, logic [31:0] e_addr, logic e_val,
                         logic [31:0] e_pc, logic [31:0] e_inst);
    checks++;
    if (ram_req !== e_req || ram_addr !== e_addr || sys_valid !== e_val ||
        ifu_pc !== e_pc || ifu_inst !== e_inst) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h inst=%h, want req=%0b addr=%h valid=%0b pc=%h inst=%h",
               name, ram_req, ram_addr, sys_valid, ifu_pc, ifu_inst,
               e_req, e_addr, e_val, e_pc, e_inst);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs just after.
  task automatic apply(vec_t v, string name);
    @(negedge clk);
    jmp_en = v.jmp; jmp_pc = v.jpc; ram_ready = v.rdy;
    rsp_valid = v.rsp; ram_inst = v.inst; sys_ready = v.srdy;
    #1;
    compare(name, v.e_req, v.e_addr, v.e_val, v.e_pc, v.e_inst);
  endtask

  initial begin
    rst_n = 1'b0; jmp_en = 1'b0; jmp_pc = 32'h0; ram_ready = 1'b0;
    rsp_valid = 1'b0; ram_inst = 32'h0; sys_ready = 1'b0;

    //           jmp   jpc           rdy   rsp   inst          srdy  req   addr          val   pc            inst
    // Streaming fetch: 8000_0000, _04, _08 with decode always ready
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hA1A1_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0,         32'h0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_0004, 1'b1, 32'h8000_0000, 32'hA1A1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h8000_0000, 32'hA1A1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hA2A2_0002, 1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h8000_0000, 32'hA1A1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_0008, 1'b1, 32'h8000_0004, 32'hA2A2_0002));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h8000_0004, 32'hA2A2_0002));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hA3A3_0003, 1'b1, 1'b0, 32'h8000_0008, 1'b0, 32'h8000_0004, 32'hA2A2_0002));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0008, 32'hA3A3_0003));
    // Memory not ready for 5 cycles: request held with constant address
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 32'h0,      1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    // Jump in WAIT to 8000_0103: in-flight response dropped, refetch at 8000_0100
    tbl.push_back(mk(1'b1, 32'h8000_0103, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h8000_000C, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hB1B1_0001, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0008, 32'hA3A3_0003));
    // Jump with decode ready in HOLD: valid masked, next fetch at 8000_0040
    tbl.push_back(mk(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h8000_0104, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    // Jump with ready in REQ: old PC accepted then dropped; PC wraps at FFFF_FFFC
    tbl.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hC0C0_0000, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hC1C1_0001, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h8000_0100, 32'hB1B1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hC1C1_0001));
    // Response outside WAIT is ignored (HOLD, then REQ)
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hC1C1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'hC1C1_0001));
    // Jump in REQ without ready, then jump coinciding with the response in WAIT
    tbl.push_back(mk(1'b1, 32'h8000_0202, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'hC1C1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0200, 1'b0, 32'hFFFF_FFFC, 32'hC1C1_0001));
    tbl.push_back(mk(1'b1, 32'h8000_0300, 1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h8000_0200, 1'b0, 32'hFFFF_FFFC, 32'hC1C1_0001));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'hFFFF_FFFC, 32'hC1C1_0001));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    compare("reset_state", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Last table row accepted a request at 8000_0300: now in WAIT. Reset there.
    @(negedge clk);
    rst_n = 1'b0; ram_ready = 1'b0; rsp_valid = 1'b0; jmp_en = 1'b0; sys_ready = 1'b0;
    #1;
    compare("reset_in_wait", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0), "late_rsp_ignored");
    apply(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0), "restart_req");
    apply(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0), "restart_rsp");
    // Decode stalls 4 cycles in HOLD: outputs stable, no new request
    for (int k = 0; k < 4; k++)
      apply(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0004, 1'b1, 32'h8000_0000, 32'h0000_0013),
            $sformatf("stall%0d", k));
    apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0004, 1'b1, 32'h8000_0000, 32'h0000_0013), "stall_release");
    apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h8000_0000, 32'h0000_0013), "after_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
